// File: rtl/elevator_call_latch.sv
// Elevator call front end: sync + debounce of 10 buttons,
// sticky floor/door requests cleared by controller acknowledgements.
module elevator_call_latch #(
   parameter int DEB_CYCLES = 4,
   parameter int CNT_W      = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] btn_floor,
   input  logic       btn_open,
   input  logic       btn_close,
   input  logic [2:0] cur_floor,
   input  logic       door_open,
   input  logic       door_close,
   output logic [7:0] req,
   output logic       open_req,
   output logic       close_req,
   output logic       any_req
);

   localparam int NCH = 10;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYCLES - 1);

   logic [NCH-1:0] raw;
   logic [NCH-1:0] sy1;
   logic [NCH-1:0] s;
   logic [NCH-1:0] d;
   logic [NCH-1:0] d_nxt;
   logic [NCH-1:0] rise;
   logic [CNT_W-1:0] cnt     [NCH];
   logic [CNT_W-1:0] cnt_nxt [NCH];
   logic [7:0] clr;
   logic [7:0] req_nxt;
   logic       open_nxt;
   logic       close_nxt;

   assign raw = {btn_close, btn_open, btn_floor};

   always_comb begin
      d_nxt = d;
      rise  = '0;
      for (int i = 0; i < NCH; i++) begin
         cnt_nxt[i] = '0;
         if (s[i] != d[i]) begin
            if (cnt[i] == LAST) begin
               d_nxt[i] = s[i];
               rise[i]  = s[i];
            end else begin
               cnt_nxt[i] = cnt[i] + 1'b1;
            end
         end
      end
   end

   // A press landing on the floor being served is absorbed (clear wins)
   always_comb begin
      clr = '0;
      if (door_open)
         clr[cur_floor] = 1'b1;
      req_nxt = (req | rise[7:0]) & ~clr;
   end

   // Open rise beats everything; door acks only clear when no new press
   always_comb begin
      open_nxt  = open_req;
      close_nxt = close_req;
      if (rise[8])
         open_nxt = 1'b1;
      else if (door_open)
         open_nxt = 1'b0;
      if (rise[8])
         close_nxt = 1'b0;
      else if (rise[9])
         close_nxt = 1'b1;
      else if (door_close)
         close_nxt = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sy1       <= '0;
         s         <= '0;
         d         <= '0;
         req       <= '0;
         open_req  <= 1'b0;
         close_req <= 1'b0;
         for (int i = 0; i < NCH; i++)
            cnt[i] <= '0;
      end else begin
         sy1       <= raw;
         s         <= sy1;
         d         <= d_nxt;
         req       <= req_nxt;
         open_req  <= open_nxt;
         close_req <= close_nxt;
         for (int i = 0; i < NCH; i++)
            cnt[i] <= cnt_nxt[i];
      end
   end

   assign any_req = |req;

endmodule

// File: tb/tb_elevator_call_latch.sv
// Bench for elevator_call_latch: directed scenarios plus random
// button/door traffic checked against a window-based reference model.
module tb_elevator_call_latch;

   localparam int DEB = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] btn_floor = '0;
   logic       btn_open = 1'b0;
   logic       btn_close = 1'b0;
   logic [2:0] cur_floor = '0;
   logic       door_open = 1'b0;
   logic       door_close = 1'b0;
   logic [7:0] req;
   logic       open_req;
   logic       close_req;
   logic       any_req;

   int vecs = 0;
   int errs = 0;

   // reference model state
   logic [9:0] rawq [$];
   int         n;
   logic [9:0] dm;
   int         flip_e [10];
   logic [7:0] m_req;
   logic       m_open;
   logic       m_close;

   elevator_call_latch #(.DEB_CYCLES(DEB), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .btn_floor(btn_floor),
      .btn_open(btn_open), .btn_close(btn_close),
      .cur_floor(cur_floor), .door_open(door_open),
      .door_close(door_close), .req(req), .open_req(open_req),
      .close_req(close_req), .any_req(any_req)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: run did not finish, got timeout exp finish");
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      rawq.delete();
      n = 0;
      dm = '0;
      for (int i = 0; i < 10; i++) flip_e[i] = -1;
      m_req = '0;
      m_open = 1'b0;
      m_close = 1'b0;
   endtask

   // synchronised level seen at edge e = raw sampled two edges earlier
   function automatic logic s_at(int e, int ch);
      logic [9:0] v;
      if (e < 2) return 1'b0;
      v = rawq[e-2];
      return v[ch];
   endfunction

   task automatic tick();
      logic [9:0] raw;
      logic [9:0] rise;
      bit ok;
      raw = {btn_close, btn_open, btn_floor};
      rise = '0;
      for (int i = 0; i < 10; i++) begin
         if (n - flip_e[i] >= DEB) begin
            ok = 1'b1;
            for (int k = 0; k < DEB; k++)
               if (s_at(n - k, i) == dm[i]) ok = 1'b0;
            if (ok) begin
               flip_e[i] = n;
               rise[i] = ~dm[i];
               dm[i] = ~dm[i];
            end
         end
      end
      m_req = m_req | rise[7:0];
      if (door_open) m_req[cur_floor] = 1'b0;
      if (rise[8]) m_open = 1'b1;
      else if (door_open) m_open = 1'b0;
      if (rise[8]) m_close = 1'b0;
      else if (rise[9]) m_close = 1'b1;
      else if (door_close) m_close = 1'b0;
      rawq.push_back(raw);
      n++;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      btn_floor = '0;
      btn_open = 1'b0;
      btn_close = 1'b0;
      door_open = 1'b0;
      door_close = 1'b0;
      cur_floor = '0;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
      vecs++;
      if ({req, open_req, close_req, any_req} !== 11'h0) begin
         errs++;
         $display("FAIL reset_outputs got %h exp %h",
                  {req, open_req, close_req, any_req}, 11'h0);
      end
      repeat (8) tick();
      vecs++;
      if ({req, open_req, close_req, any_req} !== 11'h0) begin
         errs++;
         $display("FAIL idle_outputs got %h exp %h",
                  {req, open_req, close_req, any_req}, 11'h0);
      end
   endtask

   task automatic test_latency();
      logic [7:0] exp;
      do_reset();
      btn_floor[3] = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         exp = (k >= 6) ? 8'h08 : 8'h00;
         vecs++;
         if (req !== exp || any_req !== (k >= 6) || req !== m_req) begin
            errs++;
            $display("FAIL latency edge %0d got req %h any %b exp %h model %h",
                     k, req, any_req, exp, m_req);
         end
      end
   endtask

   task automatic test_glitch();
      do_reset();
      btn_floor[5] = 1'b1;
      repeat (2) tick();
      btn_floor[5] = 1'b0;
      repeat (10) tick();
      vecs++;
      if (req !== 8'h00 || req !== m_req) begin
         errs++;
         $display("FAIL glitch_reject got %h exp %h", req, 8'h00);
      end
      btn_floor[5] = 1'b1;
      repeat (6) tick();
      vecs++;
      if (req !== 8'h20 || req !== m_req) begin
         errs++;
         $display("FAIL hold6_accept got %h exp %h", req, 8'h20);
      end
   endtask

   task automatic test_clear();
      do_reset();
      btn_floor = 8'h85;
      repeat (6) tick();
      btn_floor = 8'h00;
      repeat (8) tick();
      vecs++;
      if (req !== 8'h85) begin
         errs++;
         $display("FAIL clear_setup got %h exp %h", req, 8'h85);
      end
      door_open = 1'b1;
      cur_floor = 3'd2;
      tick();
      door_open = 1'b0;
      vecs++;
      if (req !== 8'h81 || req !== m_req) begin
         errs++;
         $display("FAIL clear_f2 got %h exp %h", req, 8'h81);
      end
      door_open = 1'b1;
      cur_floor = 3'd7;
      tick();
      door_open = 1'b0;
      vecs++;
      if (req !== 8'h01 || req !== m_req || any_req !== 1'b1) begin
         errs++;
         $display("FAIL clear_f7 got %h exp %h", req, 8'h01);
      end
   endtask

   task automatic test_same_edge();
      logic [2:0] cf;
      logic [7:0] exp;
      for (int j = 0; j < 2; j++) begin
         cf = (j == 0) ? 3'd2 : 3'd4;
         exp = (j == 0) ? 8'h00 : 8'h04;
         do_reset();
         btn_floor[2] = 1'b1;
         repeat (5) tick();
         door_open = 1'b1;
         cur_floor = cf;
         tick();
         door_open = 1'b0;
         vecs++;
         if (req !== exp || req !== m_req) begin
            errs++;
            $display("FAIL same_edge cf %0d got %h exp %h", cf, req, exp);
         end
      end
   endtask

   task automatic test_open_close();
      do_reset();
      btn_close = 1'b1;
      repeat (6) tick();
      btn_close = 1'b0;
      repeat (8) tick();
      vecs++;
      if (close_req !== 1'b1 || open_req !== 1'b0) begin
         errs++;
         $display("FAIL close_set got %b%b exp 01", open_req, close_req);
      end
      btn_open = 1'b1;
      repeat (6) tick();
      btn_open = 1'b0;
      vecs++;
      if (open_req !== 1'b1 || close_req !== 1'b0) begin
         errs++;
         $display("FAIL open_prio got %b%b exp 10", open_req, close_req);
      end
      repeat (8) tick();
      door_open = 1'b1;
      tick();
      door_open = 1'b0;
      vecs++;
      if (open_req !== 1'b0 || open_req !== m_open) begin
         errs++;
         $display("FAIL open_ack got %b exp 0", open_req);
      end
      do_reset();
      btn_open = 1'b1;
      btn_close = 1'b1;
      repeat (6) tick();
      vecs++;
      if (open_req !== 1'b1 || close_req !== 1'b0) begin
         errs++;
         $display("FAIL both_rise got %b%b exp 10", open_req, close_req);
      end
      do_reset();
      btn_close = 1'b1;
      btn_open = 1'b1;
      repeat (5) tick();
      door_close = 1'b1;
      door_open = 1'b1;
      tick();
      door_close = 1'b0;
      door_open = 1'b0;
      vecs++;
      if (open_req !== 1'b1 || open_req !== m_open) begin
         errs++;
         $display("FAIL open_set_wins got %b exp 1", open_req);
      end
      do_reset();
      btn_close = 1'b1;
      repeat (5) tick();
      door_close = 1'b1;
      tick();
      door_close = 1'b0;
      vecs++;
      if (close_req !== 1'b1 || close_req !== m_close) begin
         errs++;
         $display("FAIL close_set_wins got %b exp 1", close_req);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] exp;
      do_reset();
      btn_open = 1'b1;
      repeat (6) tick();
      btn_close = 1'b1;
      btn_floor = 8'h02;
      repeat (6) tick();
      vecs++;
      if ({req, open_req, close_req} !== {8'h02, 2'b11}) begin
         errs++;
         $display("FAIL mid_setup got %h exp %h",
                  {req, open_req, close_req}, {8'h02, 2'b11});
      end
      #3;
      rst = 1'b0;
      #1;
      vecs++;
      if ({req, open_req, close_req, any_req} !== 11'h0) begin
         errs++;
         $display("FAIL async_reset got %h exp %h",
                  {req, open_req, close_req, any_req}, 11'h0);
      end
      @(posedge clk);
      #3;
      rst = 1'b1;
      model_reset();
      for (int k = 1; k <= 7; k++) begin
         tick();
         exp = (k >= 6) ? 8'h02 : 8'h00;
         vecs++;
         if (req !== exp || open_req !== (k >= 6) || close_req !== 1'b0) begin
            errs++;
            $display("FAIL relatch edge %0d got %h %b%b exp %h %b0",
                     k, req, open_req, close_req, exp, (k >= 6));
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int t = 0; t < 3000; t++) begin
         for (int i = 0; i < 8; i++)
            if ($urandom_range(0, 9) == 0) btn_floor[i] = ~btn_floor[i];
         if ($urandom_range(0, 9) == 0) btn_open = ~btn_open;
         if ($urandom_range(0, 9) == 0) btn_close = ~btn_close;
         door_open = ($urandom_range(0, 7) == 0);
         door_close = ($urandom_range(0, 7) == 0);
         cur_floor = 3'($urandom_range(0, 7));
         tick();
         vecs++;
         if ({req, open_req, close_req, any_req} !==
             {m_req, m_open, m_close, |m_req}) begin
            errs++;
            $display("FAIL random t %0d got %h exp %h", t,
                     {req, open_req, close_req, any_req},
                     {m_req, m_open, m_close, |m_req});
         end
      end
   endtask

   initial begin
      model_reset();
      #2;
      test_reset();
      test_latency();
      test_glitch();
      test_clear();
      test_same_edge();
      test_open_close();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
